// File: rtl/priority_scanner.sv
// priority_scanner: multi-cycle priority encoder. Accepts a WIDTH-bit vector
// over valid/ready, scans it CHUNK bits per cycle (MSB end or LSB end first)
// and reports the 1-based position of the first set bit, a found flag and an
// all-ones flag. Early exit on the first nonzero chunk.
module priority_scanner #(
    parameter int WIDTH     = 40,
    parameter int CHUNK     = 10,
    parameter bit LSB_FIRST = 1'b0,
    parameter int POS_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] out_pos,
    output logic             out_found,
    output logic             out_all_set
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int IW     = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             all_set_q, all_set_d;
    logic [KW-1:0]    k_q, k_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             found_q, found_d;
    logic             aset_q, aset_d;

    logic [POS_W-1:0] base;
    logic [POS_W-1:0] lo_bit;
    logic [CHUNK-1:0] chunk;
    logic [POS_W-1:0] chunk_pos;

    // Local index of the highest set bit in a chunk (0 if the chunk is zero).
    function automatic logic [IW-1:0] hi_idx(input logic [CHUNK-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (v[i]) r = IW'(i);
        end
        return r;
    endfunction

    // Local index of the lowest set bit in a chunk (0 if the chunk is zero).
    function automatic logic [IW-1:0] lo_idx(input logic [CHUNK-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (v[i]) r = IW'(i);
        end
        return r;
    endfunction

    // Select the chunk under examination and the absolute position its
    // reported bit would have; k*CHUNK never exceeds WIDTH-CHUNK, so every
    // intermediate fits in POS_W bits without wrapping.
    always_comb begin
        base = POS_W'(k_q) * POS_W'(CHUNK);
        if (LSB_FIRST) begin
            lo_bit    = base;
            chunk     = data_q[lo_bit +: CHUNK];
            chunk_pos = base + POS_W'(lo_idx(chunk)) + POS_W'(1);
        end else begin
            lo_bit    = POS_W'(WIDTH - CHUNK) - base;
            chunk     = data_q[lo_bit +: CHUNK];
            chunk_pos = POS_W'(WIDTH) - base - POS_W'(CHUNK - 1)
                        + POS_W'(hi_idx(chunk));
        end
    end

    // Next-state and result-register update for the IDLE/SCAN/DONE controller.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        all_set_d = all_set_q;
        k_d       = k_q;
        pos_d     = pos_q;
        found_d   = found_q;
        aset_d    = aset_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d    = in_data;
                    all_set_d = &in_data;
                    k_d       = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (|chunk) begin
                    pos_d   = chunk_pos;
                    found_d = 1'b1;
                    aset_d  = all_set_q;
                    state_d = DONE;
                end else if (k_q == KW'(NCHUNK - 1)) begin
                    pos_d   = '0;
                    found_d = 1'b0;
                    aset_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            all_set_q <= 1'b0;
            k_q       <= '0;
            pos_q     <= '0;
            found_q   <= 1'b0;
            aset_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            all_set_q <= all_set_d;
            k_q       <= k_d;
            pos_q     <= pos_d;
            found_q   <= found_d;
            aset_q    <= aset_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_pos     = pos_q;
    assign out_found   = found_q;
    assign out_all_set = aset_q;

endmodule

// File: tb/tb_priority_scanner.sv
// Scoreboard bench for priority_scanner: one MSB-first and one LSB-first
// instance, directed cases plus randomized vectors against a bit-loop model.
module tb_priority_scanner;

    localparam int W = 40;

    typedef struct {
        logic [5:0] pos;
        logic       found;
        logic       all;
        int         due;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [W-1:0] in_data   [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [5:0]   out_pos   [2];
    logic         out_found [2];
    logic         out_all   [2];

    int   cyc;
    int   n_pass;
    int   n_total;
    exp_t q0[$];
    exp_t q1[$];

    bit         active [2];
    bit         taken  [2];
    int         remain [2];
    int         force_stall [2];
    logic [5:0] cap_pos   [2];
    logic       cap_found [2];
    logic       cap_all   [2];
    exp_t       mon_e;
    bit         mon_ok;

    priority_scanner #(.WIDTH(W), .CHUNK(10), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .reset(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_pos(out_pos[0]), .out_found(out_found[0]), .out_all_set(out_all[0])
    );

    priority_scanner #(.WIDTH(W), .CHUNK(10), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .reset(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_pos(out_pos[1]), .out_found(out_found[1]), .out_all_set(out_all[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: scan the whole vector bit by bit for the reported bit, then
    // derive the chunk in which the scan first meets it.
    function automatic exp_t model(input bit lsb, input logic [W-1:0] d, input int acc);
        exp_t e;
        int   p;
        int   m;
        p = 0;
        if (lsb) begin
            for (int i = W - 1; i >= 0; i--) if (d[i]) p = i + 1;
        end else begin
            for (int i = 0; i < W; i++) if (d[i]) p = i + 1;
        end
        e.pos   = 6'(p);
        e.found = (p != 0);
        e.all   = &d;
        if (p == 0)   m = 4;
        else if (lsb) m = (p - 1) / 10 + 1;
        else          m = (W - p) / 10 + 1;
        e.due = acc + m;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_vec();
        logic [63:0] a, b, c;
        int          mode;
        a    = {$urandom(), $urandom()};
        b    = {$urandom(), $urandom()};
        c    = {$urandom(), $urandom()};
        mode = $urandom_range(0, 5);
        case (mode)
            0: return '0;
            1: return '1;
            2: return W'(64'd1 << $urandom_range(0, W - 1));
            3: return W'(a & b & c);
            4: return W'(a);
            default: return W'({54'd0, a[9:0]} << (10 * $urandom_range(0, 3)));
        endcase
    endfunction

    task automatic wait_ready(input int inst);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready[inst] && n < 200);
        if (!in_ready[inst]) begin
            $display("FAIL wait_ready inst %0d: in_ready stayed 0, expected 1", inst);
            n_total++;
        end
    endtask

    task automatic send(input int inst, input logic [W-1:0] d, input bit push);
        exp_t e;
        wait_ready(inst);
        in_valid[inst] = 1'b1;
        in_data[inst]  = d;
        e = model(inst == 1, d, cyc + 1);
        if (push) begin
            if (inst == 0) q0.push_back(e);
            else           q1.push_back(e);
        end
        @(negedge clk);
        in_valid[inst] = 1'b0;
        in_data[inst]  = rnd_vec();
    endtask

    // Monitor: pops an expectation when out_valid rises, then checks hold
    // stability and in_ready while it applies random or forced backpressure.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                active[i]    = 1'b0;
                taken[i]     = 1'b0;
                out_ready[i] = 1'b0;
            end else begin
                if (taken[i]) begin
                    check($sformatf("in_ready_after_take[%0d]", i), in_ready[i], 1);
                    taken[i] = 1'b0;
                end
                if (out_valid[i]) begin
                    if (!active[i]) begin
                        mon_ok = 1'b1;
                        if (i == 0 && q0.size() > 0)      mon_e = q0.pop_front();
                        else if (i == 1 && q1.size() > 0) mon_e = q1.pop_front();
                        else mon_ok = 1'b0;
                        if (!mon_ok) begin
                            n_total++;
                            $display("FAIL unexpected_valid[%0d]: got out_valid=1, expected 0", i);
                        end else begin
                            check($sformatf("pos[%0d]", i), out_pos[i], mon_e.pos);
                            check($sformatf("found[%0d]", i), out_found[i], mon_e.found);
                            check($sformatf("all_set[%0d]", i), out_all[i], mon_e.all);
                            check($sformatf("latency_cycle[%0d]", i), cyc, mon_e.due);
                        end
                        cap_pos[i]   = out_pos[i];
                        cap_found[i] = out_found[i];
                        cap_all[i]   = out_all[i];
                        active[i]    = 1'b1;
                        remain[i]    = (force_stall[i] >= 0) ? force_stall[i]
                                                             : int'($urandom_range(0, 2));
                    end else begin
                        check($sformatf("hold_pos[%0d]", i), out_pos[i], cap_pos[i]);
                        check($sformatf("hold_found[%0d]", i), out_found[i], cap_found[i]);
                        check($sformatf("hold_all[%0d]", i), out_all[i], cap_all[i]);
                    end
                    check($sformatf("in_ready_in_done[%0d]", i), in_ready[i], 0);
                    if (remain[i] == 0) begin
                        out_ready[i] = 1'b1;
                        active[i]    = 1'b0;
                        taken[i]     = 1'b1;
                    end else begin
                        out_ready[i] = 1'b0;
                        remain[i]--;
                    end
                end else begin
                    out_ready[i] = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    initial begin
        int n;
        n_pass  = 0;
        n_total = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]    = 1'b0;
            in_data[i]     = '0;
            out_ready[i]   = 1'b0;
            active[i]      = 1'b0;
            taken[i]       = 1'b0;
            remain[i]      = 0;
            force_stall[i] = -1;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_in_ready[%0d]", i), in_ready[i], 1);
            check($sformatf("rst_out_valid[%0d]", i), out_valid[i], 0);
            check($sformatf("rst_pos[%0d]", i), out_pos[i], 0);
            check($sformatf("rst_found[%0d]", i), out_found[i], 0);
            check($sformatf("rst_all[%0d]", i), out_all[i], 0);
        end

        // Directed cases from both ends.
        send(0, W'(64'd1 << 39), 1'b1);
        send(0, W'(1), 1'b1);
        send(0, '0, 1'b1);
        send(0, '1, 1'b1);
        send(1, W'((64'd1 << 12) | (64'd1 << 35)), 1'b1);
        send(1, '1, 1'b1);
        send(1, '0, 1'b1);
        send(1, W'(64'd1 << 39), 1'b1);

        // Backpressure: five cycles with out_ready low in DONE.
        force_stall[0] = 5;
        send(0, W'(64'h00_0040_0000), 1'b1);
        wait_ready(0);
        force_stall[0] = -1;

        // Reset during the second SCAN cycle discards the transaction.
        send(0, W'(1), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("in_ready_after_reset", in_ready[0], 1);
        check("out_valid_after_reset", out_valid[0], 0);
        repeat (6) begin
            @(negedge clk);
            check("no_valid_after_abort", out_valid[0], 0);
        end

        // Randomized traffic on both instances.
        for (int t = 0; t < 100; t++) begin
            send(t % 3 == 2 ? 1 : 0, rnd_vec(), 1'b1);
        end

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || active[0] || active[1]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d/%0d results outstanding, expected 0", q0.size(), q1.size());
        end
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
